// File: rtl/io_controller_if.sv
// CPU-side io_* strobe bundle, port address bus and the interrupt request line.
// The shared 16-bit d_bus stays a plain inout so its tristate resolves at the top level.
interface io_controller_if;
  logic        io_read;
  logic        io_write;
  logic        io_push;
  logic        io_store_retaddr;
  logic        io_push_retaddr;
  logic        io_push_ints;
  logic        io_push_int_addr;
  logic [15:0] d_addr;
  logic        io_interrupt;

  modport master (
    output io_read, io_write, io_push,
    output io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
    output d_addr,
    input  io_interrupt
  );

  modport slave (
    input  io_read, io_write, io_push,
    input  io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
    input  d_addr,
    output io_interrupt
  );
endinterface

// File: rtl/io_controller.sv
// Memory-mapped I/O ports and single-level interrupt controller on the CPU io_* strobes.
// Define IO_EDGE_IRQ_EN for rising-edge IRQ capture; otherwise pending follows irq (level).
//
// state   | meaning
// IDLE    | no unmasked pending request
// REQUEST | io_interrupt high, waiting for io_store_retaddr
// SERVICE | handler running, waiting for io_push_retaddr
module io_controller #(
  parameter int NUM_PORTS = 4,
  parameter int NUM_IRQ   = 8,
  parameter int VEC_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  io_controller_if.slave          io,
  inout  wire  [15:0]             d_bus,
  input  logic [NUM_IRQ-1:0]      irq,
  input  logic [16*NUM_PORTS-1:0] in_ports,
  output logic [16*NUM_PORTS-1:0] out_ports,
  output logic [NUM_PORTS-1:0]    out_strobe
);
  localparam logic [3:0] ADDR_VEC  = 4'd14;
  localparam logic [3:0] ADDR_MASK = 4'd15;

  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;
  state_t state, state_nxt;

  logic [3:0]         addr;
  logic               addr_hi_unused;
  logic [15:0]        port_q [NUM_PORTS];
  logic [15:0]        vec_base;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] active;
  logic [15:0]        retaddr;
  logic [3:0]         svc_id;
  logic [3:0]         svc_nxt;
  logic               take;
  logic               int_q;
  logic [15:0]        port_val;
  logic [15:0]        vector;
  logic [15:0]        bus_val;
  logic               bus_en;

  assign addr           = io.d_addr[3:0];
  assign addr_hi_unused = |io.d_addr[15:4];
  assign active         = pending & mask;
  assign io.io_interrupt = int_q;

  always_comb begin
    svc_nxt = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) svc_nxt = 4'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (|active) state_nxt = REQUEST;
      end
      REQUEST: begin
        if (!(|active)) begin
          state_nxt = IDLE;
        end else if (io.io_store_retaddr) begin
          take      = 1'b1;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (io.io_push_retaddr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // io_interrupt mirrors the REQUEST state as a flop, not as decoded state bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      int_q   <= 1'b0;
      retaddr <= '0;
      svc_id  <= '0;
    end else begin
      state <= state_nxt;
      int_q <= (state_nxt == REQUEST);
      if (take) begin
        retaddr <= d_bus;
        svc_id  <= svc_nxt;
      end
    end
  end

`ifdef IO_EDGE_IRQ_EN
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] clr;

  assign clr = take ? (NUM_IRQ'(1) << svc_nxt) : '0;

  // A new edge on the bit being serviced survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      irq_prev <= '0;
    end else begin
      pending  <= (pending & ~clr) | (irq & ~irq_prev);
      irq_prev <= irq;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= irq;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_PORTS; k++) port_q[k] <= '0;
      vec_base   <= '0;
      mask       <= '0;
      out_strobe <= '0;
    end else begin
      out_strobe <= '0;
      if (io.io_read) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (addr == 4'(k)) port_q[k] <= d_bus;
        end
        if (addr == ADDR_VEC)  vec_base <= d_bus;
        if (addr == ADDR_MASK) mask     <= d_bus[NUM_IRQ-1:0];
      end
      if (io.io_write) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (addr == 4'(k)) out_strobe[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign out_ports[16*g +: 16] = port_q[g];
  end

  always_comb begin
    port_val = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (addr == 4'(k)) port_val = in_ports[16*k +: 16];
    end
    if (addr == ADDR_VEC)  port_val = vec_base;
    if (addr == ADDR_MASK) port_val = 16'(mask);
  end

  assign vector = vec_base + (16'(svc_id) << VEC_SHIFT);

  always_comb begin
    bus_val = port_val;
    if (io.io_push_retaddr)       bus_val = retaddr;
    else if (io.io_push_int_addr) bus_val = vector;
    else if (io.io_push_ints)     bus_val = 16'(active);
  end

  // Reset releases the bus at once, even with a push strobe still high.
  assign bus_en = !rst && (io.io_push_retaddr || io.io_push_int_addr ||
                           io.io_push_ints || io.io_push);
  assign d_bus  = bus_en ? bus_val : 16'bz;

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: register-access vector table, directed interrupt
// sequences, then a random run checked against a behavioural model.
module tb_io_controller;
  localparam int NP = 4;
  localparam int NI = 8;
`ifdef IO_EDGE_IRQ_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_controller_if bus ();
  wire  [15:0]      d_bus;
  logic [15:0]      tb_drv;
  logic             tb_drv_en;
  logic [NI-1:0]    irq;
  logic [16*NP-1:0] in_ports;
  logic [16*NP-1:0] out_ports;
  logic [NP-1:0]    out_strobe;

  assign d_bus = tb_drv_en ? tb_drv : 16'bz;

  io_controller #(.NUM_PORTS(NP), .NUM_IRQ(NI), .VEC_SHIFT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus),
    .d_bus     (d_bus),
    .irq       (irq),
    .in_ports  (in_ports),
    .out_ports (out_ports),
    .out_strobe(out_strobe)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.io_read          = 1'b0;
    bus.io_write         = 1'b0;
    bus.io_push          = 1'b0;
    bus.io_store_retaddr = 1'b0;
    bus.io_push_retaddr  = 1'b0;
    bus.io_push_ints     = 1'b0;
    bus.io_push_int_addr = 1'b0;
    tb_drv_en            = 1'b0;
  endtask

  function automatic int first_set(input logic [NI-1:0] v);
    for (int i = 0; i < NI; i++) if (v[i]) return i;
    return 0;
  endfunction

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          push;
    logic [3:0]    addr;
    logic [15:0]   data;
    logic [15:0]   exp_bus;
    logic [NP-1:0] exp_strobe;
  } vec_t;

  vec_t tbl [14];

  // behavioural model state
  logic [NI-1:0]    m_pend, m_mask, m_hist;
  logic [15:0]      m_vec, m_ret;
  int               m_sid;
  bit               m_svc, m_int;
  logic [16*NP-1:0] m_outs;
  logic [NP-1:0]    m_strobe;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op;
    logic [3:0]  a;
    logic [15:0] eb;
    logic [NI-1:0] act;
    bit acc, nxt_int, any_push;

    idle();
    rst      = 1'b1;
    irq      = '0;
    bus.d_addr = '0;
    in_ports = {16'h4444, 16'h3333, 16'h5A5A, 16'h1111};
    tb_drv   = 16'h5A5A;
    tb_drv_en = 1'b1;
    tick();
    tick();
    chk("reset int", 64'(bus.io_interrupt), 64'd0);
    chk("reset ports", 64'(out_ports), 64'd0);
    chk("reset strobe", 64'(out_strobe), 64'd0);
    chk("reset bus float", 64'(d_bus), 64'h5A5A);
    idle();
    rst = 1'b0;
    tick();

    // ---------------- register access table ----------------
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'd2,  16'hBEEF, 16'h0000, 4'b0100};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'd1,  16'h0000, 16'h5A5A, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'd2,  16'h0000, 16'h3333, 4'b0000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd14, 16'h0100, 16'h0000, 4'b0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'd14, 16'h0000, 16'h0100, 4'b0000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd15, 16'hFFFF, 16'h0000, 4'b0000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'd15, 16'h0000, 16'h00FF, 4'b0000};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, 4'b0001};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'd9,  16'h0000, 16'h0000, 4'b0000};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd9,  16'h0000, 16'h0000, 4'b0000};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'd3,  16'hCAFE, 16'h0000, 4'b1000};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4'd0,  16'h0000, 16'h1111, 4'b0000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'd9,  16'hDEAD, 16'h0000, 4'b0000};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'd14, 16'h0000, 16'h0100, 4'b0000};

    for (int i = 0; i < 14; i++) begin
      bus.io_read  = tbl[i].rd;
      bus.io_write = tbl[i].wr;
      bus.io_push  = tbl[i].push;
      bus.d_addr   = {12'h000, tbl[i].addr};
      tb_drv       = tbl[i].data;
      tb_drv_en    = !tbl[i].push;
      #1;
      if (tbl[i].push) chk("table push", 64'(d_bus), 64'(tbl[i].exp_bus));
      tick();
      idle();
      chk("table strobe", 64'(out_strobe), 64'(tbl[i].exp_strobe));
      if (tbl[i].rd && tbl[i].addr < 4'(NP))
        chk("table port", 64'(out_ports[16*tbl[i].addr +: 16]), 64'(tbl[i].data));
    end
    tick();
    chk("strobe one cycle", 64'(out_strobe), 64'd0);
    chk("port file", 64'(out_ports), 64'hCAFE_BEEF_0000_0000);

    // ---------------- IRQ 3 full service ----------------
    irq[3] = 1'b1;
    tick();
    if (EDGE_MODE) irq[3] = 1'b0;
    chk("irq3 int N+1", 64'(bus.io_interrupt), 64'd0);
    tick();
    chk("irq3 int N+2", 64'(bus.io_interrupt), 64'd1);
    bus.io_store_retaddr = 1'b1;
    tb_drv = 16'h1234;
    tb_drv_en = 1'b1;
    tick();
    idle();
    irq[3] = 1'b0;
    chk("int after store", 64'(bus.io_interrupt), 64'd0);
    bus.io_push_int_addr = 1'b1;
    #1;
    chk("vector irq3", 64'(d_bus), 64'h010C);
    tick();
    idle();
    bus.io_push_retaddr = 1'b1;
    #1;
    chk("retaddr push", 64'(d_bus), 64'h1234);
    tick();
    idle();
    bus.io_push_ints = 1'b1;
    #1;
    chk("ints after return", 64'(d_bus), 64'h0000);
    tick();
    idle();
    chk("int idle after return", 64'(bus.io_interrupt), 64'd0);

    // ---------------- IRQ 5 and 2 together ----------------
    irq[5] = 1'b1;
    irq[2] = 1'b1;
    tick();
    if (EDGE_MODE) irq = '0;
    tick();
    chk("dual int", 64'(bus.io_interrupt), 64'd1);
    bus.io_store_retaddr = 1'b1;
    tb_drv = 16'h2222;
    tb_drv_en = 1'b1;
    tick();
    idle();
    irq[2] = 1'b0;
    bus.io_push_int_addr = 1'b1;
    #1;
    chk("vector lowest wins", 64'(d_bus), 64'h0108);
    tick();
    idle();
    bus.io_push_retaddr = 1'b1;
    #1;
    chk("retaddr dual", 64'(d_bus), 64'h2222);
    tick();
    idle();
    chk("int low after return", 64'(bus.io_interrupt), 64'd0);
    tick();
    chk("irq5 reasserts", 64'(bus.io_interrupt), 64'd1);
    bus.io_store_retaddr = 1'b1;
    tb_drv = 16'h3333;
    tb_drv_en = 1'b1;
    tick();
    idle();
    irq[5] = 1'b0;
    bus.io_push_int_addr = 1'b1;
    #1;
    chk("vector irq5", 64'(d_bus), 64'h0114);
    tick();
    idle();
    bus.io_push_retaddr = 1'b1;
    tick();
    idle();
    tick();
    chk("all serviced", 64'(bus.io_interrupt), 64'd0);

    // ---------------- mask cleared while requesting ----------------
    irq[1] = 1'b1;
    tick();
    if (EDGE_MODE) irq[1] = 1'b0;
    tick();
    chk("irq1 int", 64'(bus.io_interrupt), 64'd1);
    bus.io_read = 1'b1;
    bus.d_addr = 16'h000F;
    tb_drv = 16'h0000;
    tb_drv_en = 1'b1;
    tick();
    idle();
    chk("int same cycle as mask", 64'(bus.io_interrupt), 64'd1);
    tick();
    chk("int drops on mask", 64'(bus.io_interrupt), 64'd0);
    bus.io_push_ints = 1'b1;
    #1;
    chk("ints masked", 64'(d_bus), 64'h0000);
    tick();
    idle();
    irq[1] = 1'b0;

    // ---------------- reset during service ----------------
    bus.io_read = 1'b1;
    bus.d_addr = 16'h000F;
    tb_drv = 16'h00FF;
    tb_drv_en = 1'b1;
    irq[0] = 1'b1;
    tick();
    idle();
    if (EDGE_MODE) irq[0] = 1'b0;
    tick();
    chk("pre-reset int", 64'(bus.io_interrupt), 64'd1);
    bus.io_store_retaddr = 1'b1;
    bus.io_write = 1'b1;
    bus.d_addr = 16'h0002;
    tb_drv = 16'h4321;
    tb_drv_en = 1'b1;
    tick();
    idle();
    chk("strobe before reset", 64'(out_strobe), 64'b0100);
    bus.io_push_retaddr = 1'b1;
    #1;
    chk("retaddr before reset", 64'(d_bus), 64'h4321);
    rst = 1'b1;
    irq = '0;
    tb_drv = 16'hA5A5;
    tb_drv_en = 1'b1;
    #1;
    chk("reset int async", 64'(bus.io_interrupt), 64'd0);
    chk("reset ports async", 64'(out_ports), 64'd0);
    chk("reset strobe async", 64'(out_strobe), 64'd0);
    chk("bus released in reset", 64'(d_bus), 64'hA5A5);
    idle();
    tick();
    rst = 1'b0;
    tick();
    bus.io_push = 1'b1;
    bus.d_addr = 16'h000F;
    #1;
    chk("mask after reset", 64'(d_bus), 64'h0000);
    bus.d_addr = 16'h000E;
    #1;
    chk("vec_base after reset", 64'(d_bus), 64'h0000);
    idle();
    bus.io_push_retaddr = 1'b1;
    #1;
    chk("stale retaddr after reset", 64'(d_bus), 64'h0000);
    tick();
    idle();
    tick();
    chk("int after reset", 64'(bus.io_interrupt), 64'd0);

    // ---------------- random run against model ----------------
    m_pend = '0; m_mask = '0; m_hist = '0;
    m_vec = '0; m_ret = '0; m_sid = 0;
    m_svc = 1'b0; m_int = 1'b0;
    m_outs = '0; m_strobe = '0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      op = $urandom_range(0, 7);
      a  = 4'($urandom_range(0, 15));
      case (op)
        1: bus.io_read = 1'b1;
        2: bus.io_write = 1'b1;
        3: begin bus.io_read = 1'b1; bus.io_write = 1'b1; end
        4: bus.io_push = 1'b1;
        5: bus.io_store_retaddr = 1'b1;
        6: bus.io_push_retaddr = 1'b1;
        7: {bus.io_push_retaddr, bus.io_push_int_addr, bus.io_push_ints, bus.io_push} =
             4'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) irq = irq ^ (NI'(1) << $urandom_range(0, NI - 1));
      in_ports   = {$urandom, $urandom};
      bus.d_addr = {12'($urandom), a};
      tb_drv     = 16'($urandom);
      any_push   = bus.io_push_retaddr || bus.io_push_int_addr ||
                   bus.io_push_ints || bus.io_push;
      tb_drv_en  = !any_push;
      #1;

      act = m_pend & m_mask;
      if (bus.io_push_retaddr)       eb = m_ret;
      else if (bus.io_push_int_addr) eb = m_vec + 16'(m_sid * 4);
      else if (bus.io_push_ints)     eb = 16'(act);
      else if (a < 4'(NP))           eb = in_ports[16*a +: 16];
      else if (a == 4'd14)           eb = m_vec;
      else if (a == 4'd15)           eb = 16'(m_mask);
      else                           eb = 16'h0000;

      chk("rand int", 64'(bus.io_interrupt), 64'(m_int));
      chk("rand strobe", 64'(out_strobe), 64'(m_strobe));
      chk("rand ports", 64'(out_ports), 64'(m_outs));
      if (any_push) chk("rand bus", 64'(d_bus), 64'(eb));

      acc     = m_int && bus.io_store_retaddr && (act != '0);
      nxt_int = !m_svc && (act != '0) && !acc;
      if (acc) begin
        m_ret = tb_drv;
        m_sid = first_set(act);
        m_svc = 1'b1;
      end else if (m_svc && bus.io_push_retaddr) begin
        m_svc = 1'b0;
      end
      if (EDGE_MODE) begin
        if (acc) m_pend[m_sid] = 1'b0;
        m_pend = m_pend | (irq & ~m_hist);
      end else begin
        m_pend = irq;
      end
      m_hist = irq;
      if (bus.io_read) begin
        if (a < 4'(NP))      m_outs[16*a +: 16] = tb_drv;
        else if (a == 4'd14) m_vec = tb_drv;
        else if (a == 4'd15) m_mask = tb_drv[NI-1:0];
      end
      m_strobe = (bus.io_write && a < 4'(NP)) ? NP'(1) << a : '0;
      m_int = nxt_int;
      tick();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/io_controller.md
# io_controller

Memory-mapped I/O and interrupt controller, the responder end of the CPU's `io_*` strobe interface. Holds output port registers, samples input ports, latches external interrupt requests, and raises `io_interrupt` to the control unit. Serves the interrupt entry and return handshake: return-address store, vector push, return-address push, and pending/mask status push. Sits beside the data memory on `d_bus`/`d_addr`. The CPU's `io_addresser` places the 4-bit port number on `d_addr[3:0]`.

## Interface
Parameters:
- `NUM_PORTS`, 4: general I/O ports at addresses 0..NUM_PORTS-1 (max 14).
- `NUM_IRQ`, 8: external interrupt lines; index 0 has highest priority (max 16).
- `VEC_SHIFT`, 2: vector spacing, log2 words.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `io_read`  in  1  latch `d_bus` into register at `d_addr[3:0]`.
- `io_write`  in  1  commit: pulse `out_strobe` for port `d_addr[3:0]`.
- `io_push`  in  1  drive `d_bus` with input port `d_addr[3:0]`.
- `io_store_retaddr`  in  1  latch `d_bus` as return address; begin service.
- `io_push_retaddr`  in  1  drive saved return address; end service.
- `io_push_ints`  in  1  drive `{pending & mask}` zero-extended to 16 bits.
- `io_push_int_addr`  in  1  drive vector of the serviced IRQ.
- `io_interrupt`  out  1  registered interrupt request to the control unit.
- `d_bus`  inout  16  shared data bus; high-Z unless pushing.
- `d_addr`  in  16  address bus; only [3:0] used.
- `irq`  in  NUM_IRQ  external requests, synchronous to `clk`.
- `in_ports`  in  16*NUM_PORTS  flattened input ports; port k is bits [16k+15:16k].
- `out_ports`  out  16*NUM_PORTS  flattened output port registers.
- `out_strobe`  out  NUM_PORTS  one-cycle commit pulse per port.

## Operation
- Address map: 0..NUM_PORTS-1 are general ports, 14 is `vec_base`, 15 is `mask` (bit=1 enables). Reads and writes to other addresses are ignored. `io_push` from an unmapped address drives 0.
- `io_read` writes `out_ports[a]`, `vec_base`, or `mask`. `io_push` of address 14 or 15 returns that register.
- IRQ capture: a bit of `pending` is set on the rising edge of `irq[i]` (previous-cycle sample low, current high).
- Pending bits clear only by service or by reset. If a set and a clear hit the same bit in the same cycle, the set wins.
- FSM `IDLE → REQUEST → SERVICE → IDLE`:
  - IDLE: moves to REQUEST when `pending & mask` is nonzero.
  - REQUEST: moves back to IDLE if `pending & mask` drops to zero, for example because the mask was written.
  - REQUEST + `io_store_retaddr`: latch `retaddr` from `d_bus`; capture `svc_id` as the lowest set index of `pending & mask`; clear `pending[svc_id]`; go to SERVICE.
  - SERVICE + `io_push_retaddr`: go to IDLE. No nesting; new requests stay pending.
- `io_store_retaddr` outside REQUEST and `io_push_retaddr` outside SERVICE are ignored; the push still drives the stale `retaddr`.
- Vector value is `vec_base + (svc_id << VEC_SHIFT)`, 16-bit modulo wrap.
- Bus drive is combinational while a push strobe is high. If several pushes are high at once, priority is `io_push_retaddr` > `io_push_int_addr` > `io_push_ints` > `io_push`; only one value is driven.

## Timing
- `io_interrupt` is a registered output. It is high in every cycle the FSM is in REQUEST, so it first rises one cycle after the state that enables it: an IRQ edge sampled at cycle N gives `io_interrupt` high at N+2. It falls the cycle after `io_store_retaddr`.
- `io_read` at cycle N: the register holds the new value from N+1.
- `io_write` at cycle N: `out_strobe[a]` is high for exactly cycle N+1. If it coincides with `io_read` to the same address, `out_ports[a]` already holds the new value during the strobe.
- `io_push_int_addr` is valid from the cycle after `io_store_retaddr`.
- Reset values: `io_interrupt`=0, `out_ports`=0, `out_strobe`=0, `pending`=0, `mask`=0, `vec_base`=0, `retaddr`=0, `svc_id`=0, FSM=IDLE, `d_bus`=Z, edge-detect history=0. Reset asserted mid-service abandons the service with no residue.

## Configuration
- `IO_EDGE_IRQ_EN` defined: edge-triggered capture as described above.
- Not defined: level-sensitive. `pending` equals `irq` each cycle, service clears nothing, and the device must deassert `irq` before the handler returns.

## Test plan
- Reset with mask=0xFF, `irq[3]` pulsed 1→0 → `io_interrupt` high 2 cycles later. `io_store_retaddr` with `d_bus`=0x1234 → `io_interrupt` low next cycle. `io_push_int_addr` with `vec_base`=0x0100 → `d_bus`=0x010C.
- `io_push_retaddr` in SERVICE → `d_bus`=0x1234, FSM returns to IDLE, `io_push_ints` then reads 0x0000.
- `irq[5]` and `irq[2]` rise in the same cycle → service `svc_id`=2; after return `io_interrupt` re-asserts for IRQ 5.
- Pending IRQ 1, then `io_read` address 15 with 0x0000 while in REQUEST → `io_interrupt` drops, FSM returns to IDLE, `io_push_ints`=0.
- `io_read`+`io_write` address 2 with `d_bus`=0xBEEF → `out_ports[2]`=0xBEEF and `out_strobe[2]`=1 for one cycle. `io_push` address 1 with `in_ports[1]`=0x5A5A → `d_bus`=0x5A5A.
- Assert `rst` during SERVICE → all outputs return to reset values and `d_bus` goes Z immediately.
